// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d layer sequencer.
// Holds the default counter widths and the sequencer state encoding.
package conv2d_pkg;

    localparam int CH_W_DEF  = 8;
    localparam int ROW_W_DEF = 8;

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_WAIT_KERNEL   = 4'd1,
        S_SET_LAST      = 4'd2,
        S_LOAD          = 4'd3,
        S_WAIT_READY    = 4'd4,
        S_WAIT_ROW      = 4'd5,
        S_ISSUE         = 4'd6,
        S_GUARD         = 4'd7,
        S_WAIT_ROW_DONE = 4'd8,
        S_FINISH        = 4'd9,
        S_PE_RST        = 4'd10
    } state_t;

endpackage

// File: rtl/conv2d_chan_row_counter.sv
// Nested channel (b) / row (r) counter with latched layer geometry.
// The last-row / last-channel flags compare against the latched counts.
module conv2d_chan_row_counter
    import conv2d_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             row_inc,
    input  logic             chan_inc,
    input  logic             row_clr,
    input  logic [CH_W-1:0]  num_ch,
    input  logic [ROW_W-1:0] num_rows,
    output logic [CH_W-1:0]  b,
    output logic [ROW_W-1:0] r,
    output logic             is_last_row,
    output logic             is_last_chan
);

    logic [CH_W-1:0]  c_q, c_d, b_q, b_d;
    logic [ROW_W-1:0] h_q, h_d, r_q, r_d;

    // Next-value logic: load latches the geometry, steps never wrap
    always_comb begin
        c_d = c_q;
        h_d = h_q;
        b_d = b_q;
        r_d = r_q;
        if (load) begin
            c_d = num_ch;
            h_d = num_rows;
            b_d = '0;
            r_d = '0;
        end else if (row_inc) begin
            r_d = r_q + ROW_W'(1);
        end else if (chan_inc) begin
            r_d = '0;
            b_d = b_q + CH_W'(1);
        end else if (row_clr) begin
            r_d = '0;
        end
    end

    // Counter and geometry registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            c_q <= '0;
            h_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            h_q <= h_d;
            b_q <= b_d;
            r_q <= r_d;
        end
    end

    assign b            = b_q;
    assign r            = r_q;
    assign is_last_row  = (r_q == h_q - ROW_W'(1));
    assign is_last_chan = (b_q == c_q - CH_W'(1));

endmodule

// File: rtl/conv2d_layer_sequencer.sv
// Sequences kernel loads and row streams for one conv layer over
// C input channels and H output rows, handshaking with the PE.
module conv2d_layer_sequencer
    import conv2d_pkg::*;
#(
    parameter int CH_W  = CH_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [CH_W-1:0]  cfg_num_channels,
    input  logic [ROW_W-1:0] cfg_num_rows,
    input  logic             kernel_valid,
    input  logic             row_avail,
    input  logic             pe_idle,
    input  logic             pe_ready,
    output logic             Load_kernel_reg,
    output logic             Stream_mid_row,
    output logic             Stream_last_row,
    output logic             last_channel,
    output logic [CH_W-1:0]  b_counter_output,
    output logic             pe_reset_n,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic             lc_q, lc_d;
    logic             cnt_load, row_inc, chan_inc, row_clr;
    logic             is_last_row, is_last_chan;
    logic [ROW_W-1:0] r_unused;

    conv2d_chan_row_counter #(
        .CH_W  (CH_W),
        .ROW_W (ROW_W)
    ) u_cnt (
        .clk          (clk),
        .Reset        (Reset),
        .load         (cnt_load),
        .row_inc      (row_inc),
        .chan_inc     (chan_inc),
        .row_clr      (row_clr),
        .num_ch       (cfg_num_channels),
        .num_rows     (cfg_num_rows),
        .b            (b_counter_output),
        .r            (r_unused),
        .is_last_row  (is_last_row),
        .is_last_chan (is_last_chan)
    );

    // Next-state, counter steps and last_channel flag
    always_comb begin
        state_d  = state_q;
        lc_d     = lc_q;
        cnt_load = 1'b0;
        row_inc  = 1'b0;
        chan_inc = 1'b0;
        row_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (cfg_num_channels != '0)
                          && (cfg_num_rows != '0)) begin
                    cnt_load = 1'b1;
                    lc_d     = 1'b0;
                    state_d  = S_WAIT_KERNEL;
                end
            end
            S_WAIT_KERNEL: begin
                if (pe_idle && kernel_valid) begin
                    if (is_last_chan) begin
                        lc_d    = 1'b1;
                        state_d = S_SET_LAST;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_SET_LAST:   state_d = S_LOAD;
            S_LOAD:       state_d = S_WAIT_READY;
            S_WAIT_READY: if (pe_ready) state_d = S_WAIT_ROW;
            S_WAIT_ROW: begin
                if (pe_idle && row_avail) state_d = S_ISSUE;
            end
            S_ISSUE:      state_d = S_GUARD;
            S_GUARD:      state_d = S_WAIT_ROW_DONE;
            S_WAIT_ROW_DONE: begin
                if (pe_idle) begin
                    if (!is_last_row) begin
                        row_inc = 1'b1;
                        state_d = S_WAIT_ROW;
                    end else if (!is_last_chan) begin
                        chan_inc = 1'b1;
                        state_d  = S_WAIT_KERNEL;
                    end else begin
                        row_clr = 1'b1;
                        lc_d    = 1'b0;
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH:     state_d = S_PE_RST;
            S_PE_RST:     state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // State and last_channel registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            lc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
        end
    end

    assign Load_kernel_reg = (state_q == S_LOAD);
    assign Stream_mid_row  = (state_q == S_ISSUE) && !is_last_row;
    assign Stream_last_row = (state_q == S_ISSUE) && is_last_row;
    assign last_channel    = lc_q;
    assign done            = (state_q == S_FINISH);
    assign busy            = (state_q != S_IDLE);
    assign pe_reset_n      = !(Reset || (state_q == S_FINISH));

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Randomized bench for conv2d_layer_sequencer against an event-list model.
// The model lists the command events a layer of C channels x H rows must emit.
module tb_conv2d_layer_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] cfg_num_channels;
    logic [7:0] cfg_num_rows;
    logic       kernel_valid;
    logic       row_avail;
    logic       pe_idle;
    logic       pe_ready;
    logic       Load_kernel_reg;
    logic       Stream_mid_row;
    logic       Stream_last_row;
    logic       last_channel;
    logic [7:0] b_counter_output;
    logic       pe_reset_n;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // event code = kind*1000 + b ; kinds: 1 last_channel rise, 2 load,
    // 3 mid-row stream, 4 last-row stream, 5 done
    int expq[$];
    int cur_c = 1;
    int cur_h = 1;
    int cyc = 0;
    int lch_cyc = -10;
    int done_cyc = -10;
    int done_cnt = 0;
    bit lc_prev = 1'b0;
    bit no_pulse = 1'b0;
    bit rand_in = 1'b0;
    bit rand_pe = 1'b0;
    int idle_cnt = 0;
    int rdy_cnt = 0;

    always #5 clk = ~clk;

    conv2d_layer_sequencer dut (
        .clk              (clk),
        .Reset            (Reset),
        .start            (start),
        .cfg_num_channels (cfg_num_channels),
        .cfg_num_rows     (cfg_num_rows),
        .kernel_valid     (kernel_valid),
        .row_avail        (row_avail),
        .pe_idle          (pe_idle),
        .pe_ready         (pe_ready),
        .Load_kernel_reg  (Load_kernel_reg),
        .Stream_mid_row   (Stream_mid_row),
        .Stream_last_row  (Stream_last_row),
        .last_channel     (last_channel),
        .b_counter_output (b_counter_output),
        .pe_reset_n       (pe_reset_n),
        .busy             (busy),
        .done             (done)
    );

    // PE model: busy for a latency after each command, ready 2 cycles after load
    always @(posedge clk) begin
        if (!pe_reset_n) begin
            idle_cnt <= 0;
            rdy_cnt  <= 0;
        end else begin
            if (Load_kernel_reg || Stream_mid_row || Stream_last_row)
                idle_cnt <= rand_pe ? int'($urandom_range(1, 7)) : 5;
            else if (idle_cnt > 0)
                idle_cnt <= idle_cnt - 1;
            if (Load_kernel_reg)
                rdy_cnt <= 2;
            else if (rdy_cnt > 0)
                rdy_cnt <= rdy_cnt - 1;
        end
    end
    assign pe_idle  = (idle_cnt == 0);
    assign pe_ready = (rdy_cnt == 0);

    function automatic void build_exp(int c, int h);
        expq.delete();
        for (int bb = 0; bb < c; bb++) begin
            if (bb == c - 1) expq.push_back(1000 + bb);
            expq.push_back(2000 + bb);
            for (int rr = 0; rr < h; rr++)
                expq.push_back((rr < h - 1 ? 3000 : 4000) + bb);
        end
        expq.push_back(5000 + c - 1);
    endfunction

    task automatic fail_line(string name, int act, int req);
        errors++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic see_event(int code);
        checks++;
        if (expq.size() == 0) begin
            fail_line("unexpected_event", code, -1);
        end else begin
            int e;
            e = expq.pop_front();
            if (e != code) fail_line("event_order", code, e);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (Reset) begin
            checks++;
            if ({Load_kernel_reg, Stream_mid_row, Stream_last_row,
                 last_channel, busy, done, pe_reset_n} !== 7'b0)
                fail_line("reset_outputs",
                          int'({Load_kernel_reg, Stream_mid_row,
                                Stream_last_row, last_channel,
                                busy, done, pe_reset_n}), 0);
        end else begin
            int np;
            np = int'(Load_kernel_reg) + int'(Stream_mid_row)
               + int'(Stream_last_row);
            checks++;
            if (np > 1) fail_line("cmd_onehot", np, 1);
            checks++;
            if (pe_reset_n !== !done)
                fail_line("pe_reset_n_vs_done", int'(pe_reset_n), int'(!done));
            if (no_pulse && np != 0) fail_line("pulse_in_stall", np, 0);
            if (last_channel && int'(b_counter_output) != cur_c - 1)
                fail_line("last_channel_early", int'(b_counter_output), cur_c - 1);
            if (last_channel && !lc_prev) begin
                lch_cyc = cyc;
                see_event(1000 + int'(b_counter_output));
            end
            if (Load_kernel_reg) begin
                see_event(2000 + int'(b_counter_output));
                if (int'(b_counter_output) == cur_c - 1) begin
                    checks++;
                    if (cyc != lch_cyc + 1)
                        fail_line("lk_after_lastch", cyc - lch_cyc, 1);
                end
            end
            if (Stream_mid_row)  see_event(3000 + int'(b_counter_output));
            if (Stream_last_row) see_event(4000 + int'(b_counter_output));
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
                see_event(5000 + int'(b_counter_output));
            end
            if (cyc == done_cyc + 1) begin
                checks++;
                if (busy !== 1'b1) fail_line("busy_pe_rst", int'(busy), 1);
            end
            if (cyc == done_cyc + 2) begin
                checks++;
                if (busy !== 1'b0) fail_line("busy_after_done", int'(busy), 0);
            end
        end
        lc_prev = last_channel;
    end

    task automatic start_layer(int c, int h);
        @(negedge clk);
        cur_c = c;
        cur_h = h;
        build_exp(c, h);
        cfg_num_channels = 8'(c);
        cfg_num_rows     = 8'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_layer(int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            if (rand_in) begin
                kernel_valid = ($urandom_range(0, 3) != 0);
                row_avail    = ($urandom_range(0, 3) != 0);
            end
            n++;
        end
        checks++;
        if (done_cnt == d0) fail_line("done_timeout", n, budget);
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) fail_line("events_missing", expq.size(), 0);
        kernel_valid = 1'b1;
        row_avail    = 1'b1;
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        cfg_num_channels = '0;
        cfg_num_rows = '0;
        kernel_valid = 1'b1;
        row_avail = 1'b1;

        // hand-derived pins on the model itself
        build_exp(2, 3);
        checks++;
        if (expq.size() != 10) fail_line("model_len_2x3", expq.size(), 10);
        checks++;
        if (expq[4] != 1001 || expq[5] != 2001)
            fail_line("model_lastch_2x3", expq[4], 1001);
        build_exp(1, 1);
        checks++;
        if (expq.size() != 4 || expq[0] != 1000 || expq[1] != 2000
            || expq[2] != 4000 || expq[3] != 5000)
            fail_line("model_1x1", expq.size(), 4);
        expq.delete();

        repeat (3) @(negedge clk);
        checks++;
        if (pe_reset_n !== 1'b0) fail_line("pe_reset_n_in_reset", int'(pe_reset_n), 0);
        Reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, last_channel, b_counter_output} !== 11'b0)
            fail_line("post_reset_idle", int'({busy, done, last_channel}), 0);

        // directed layers from the datasheet examples
        start_layer(2, 3);
        finish_layer(2000);
        start_layer(1, 1);
        finish_layer(2000);

        // stalls: kernel_valid low 10 cycles, then row_avail low 20 cycles
        kernel_valid = 1'b0;
        row_avail = 1'b0;
        start_layer(1, 2);
        no_pulse = 1'b1;
        repeat (10) @(negedge clk);
        no_pulse = 1'b0;
        kernel_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!Load_kernel_reg && n < 50) begin
                @(posedge clk);
                #2;
                n++;
            end
            checks++;
            if (!Load_kernel_reg) fail_line("lk_timeout", n, 50);
        end
        @(negedge clk);
        no_pulse = 1'b1;
        repeat (20) @(negedge clk);
        no_pulse = 1'b0;
        row_avail = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (Stream_mid_row !== 1'b1)
            fail_line("mid_row_t_plus_1", int'(Stream_mid_row), 1);
        finish_layer(2000);

        // ignored starts: zero rows, zero channels
        @(negedge clk);
        cfg_num_channels = 8'd2;
        cfg_num_rows = 8'd0;
        start = 1'b1;
        @(negedge clk);
        cfg_num_channels = 8'd0;
        cfg_num_rows = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) fail_line("zero_cfg_ignored", int'(busy), 0);

        // start while busy must not disturb the running layer
        start_layer(2, 2);
        repeat (8) @(negedge clk);
        cfg_num_channels = 8'd3;
        cfg_num_rows = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_layer(2000);

        // mid-layer reset during row 1 of channel 0
        start_layer(3, 4);
        begin
            int n;
            n = 0;
            while (!Stream_mid_row && n < 200) begin
                @(posedge clk);
                #2;
                n++;
            end
            checks++;
            if (!Stream_mid_row) fail_line("first_row_timeout", n, 200);
        end
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        expq.delete();
        #1;
        checks++;
        if (pe_reset_n !== 1'b0) fail_line("reset_comb_pe_rst", int'(pe_reset_n), 0);
        @(posedge clk);
        #2;
        checks++;
        if ({Load_kernel_reg, Stream_mid_row, Stream_last_row, last_channel,
             busy, done, b_counter_output} !== 14'b0)
            fail_line("abort_outputs", int'(busy), 0);
        @(negedge clk);
        Reset = 1'b0;
        start_layer(1, 2);
        finish_layer(2000);

        // randomized layers with random stalls and PE latency
        rand_in = 1'b1;
        rand_pe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start_layer(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
            finish_layer(5000);
        end
        rand_in = 1'b0;

        // counter extremes
        start_layer(255, 1);
        finish_layer(30000);
        start_layer(1, 255);
        finish_layer(30000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_layer_sequencer.md
CONV2D_LAYER_SEQUENCER -- requirements
Module: conv2d_layer_sequencer

Interface
REQ-001 CH_W, 8, width of channel count and channel index.
REQ-002 ROW_W, 8, width of row count and row index.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to run one conv layer.
REQ-006 cfg_num_channels  in  CH_W  input-channel count C; sampled only when start is accepted.
REQ-007 cfg_num_rows  in  ROW_W  output-row count H; sampled only when start is accepted.
REQ-008 kernel_valid  in  1  kernel for the next channel is present at the PE kernel port.
REQ-009 row_avail  in  1  line buffer holds the next row window.
REQ-010 pe_idle  in  1  PE_with_buffers_IDLE from the PE control unit.
REQ-011 pe_ready  in  1  PE_ready from the PE control unit.
REQ-012 Load_kernel_reg  out  1  kernel-load command pulse.
REQ-013 Stream_mid_row  out  1  non-final-row stream command pulse.
REQ-014 Stream_last_row  out  1  final-row stream command pulse.
REQ-015 last_channel  out  1  level; current channel is C-1.
REQ-016 b_counter_output  out  CH_W  current channel index b.
REQ-017 pe_reset_n  out  1  active-low reset to the PE control unit.
REQ-018 busy  out  1  layer in progress.
REQ-019 done  out  1  one-cycle layer-complete pulse.

Function
REQ-020 States: S_IDLE, S_WAIT_KERNEL, S_SET_LAST, S_LOAD, S_WAIT_READY, S_WAIT_ROW, S_ISSUE, S_GUARD, S_WAIT_ROW_DONE, S_FINISH, S_PE_RST.
REQ-021 S_IDLE: start with C!=0 and H!=0 latches cfg, sets b=0, r=0, and goes to S_WAIT_KERNEL; start with a zero cfg field, or start in any other state, is ignored.
REQ-022 S_WAIT_KERNEL: on pe_idle&kernel_valid, go to S_SET_LAST if b==C-1, else go to S_LOAD.
REQ-023 S_SET_LAST: sets last_channel; no command pulse this cycle, so the PE sees last_channel alone while idle; then go to S_LOAD.
REQ-024 S_LOAD: Load_kernel_reg=1 for exactly one cycle, then S_WAIT_READY; S_WAIT_READY: on pe_ready, go to S_WAIT_ROW.
REQ-025 S_WAIT_ROW: on pe_idle&row_avail, go to S_ISSUE; S_ISSUE drives Stream_mid_row if r<H-1, else Stream_last_row, for one cycle, then S_GUARD.
REQ-026 S_GUARD: lasts one cycle with pe_idle ignored (PE is leaving idle), then S_WAIT_ROW_DONE.
REQ-027 S_WAIT_ROW_DONE, on pe_idle: if r<H-1, then r+1 and S_WAIT_ROW; else r=0, and if b<C-1 then b+1 and S_WAIT_KERNEL, else S_FINISH.
REQ-028 S_FINISH: done=1, pe_reset_n=0 and last_channel cleared for one cycle, then S_PE_RST; S_PE_RST lasts one cycle (PE passes reset to idle), then S_IDLE.
REQ-029 Command outputs are decoded from registered state only; at most one of Load_kernel_reg, Stream_mid_row and Stream_last_row is high in any cycle.
REQ-030 b_counter_output is stable from S_WAIT_KERNEL through the last row of that channel; it is 0 for the first channel (PE adds bias).
REQ-031 Once set, last_channel is held until S_FINISH; it is never asserted before b==C-1.
REQ-032 busy=1 in every state except S_IDLE.
REQ-033 If H==1, each channel issues only Stream_last_row; if C==1, S_SET_LAST precedes the only load.
REQ-034 Counters do not wrap: b stays in [0,C-1] and r stays in [0,H-1]; C=2^CH_W-1 and H=2^ROW_W-1 are supported.

Reset
REQ-035 Reset high at a clock edge puts the block in S_IDLE with b=r=0, last_channel=0, all pulses 0, busy=0 and done=0.
REQ-036 pe_reset_n=0 combinationally whenever Reset is high; a mid-layer Reset aborts the layer with no done pulse.

Structure
REQ-037 Shared package conv2d_pkg holds the state encoding and the CH_W/ROW_W defaults.
REQ-038 One sub-module: conv2d_chan_row_counter, a nested b/r counter with is_last_row and is_last_chan flags.

Verification
REQ-039 C=2, H=3, kernel_valid=row_avail=1, PE model (idle low 5 cycles after each command, pe_ready 2 cycles after load) -> LK(b=0), mid, mid, last, last_channel rises, LK(b=1) one cycle later, mid, mid, last, done with pe_reset_n low for one cycle, busy low 2 cycles after done.
REQ-040 C=1, H=1 -> last_channel rises, LK one cycle later, one Stream_last_row, done; Stream_mid_row is never asserted.
REQ-041 kernel_valid low 10 cycles then row_avail low 20 cycles -> no pulses during the stalls; row_avail rising at cycle t gives Stream_mid_row at t+1.
REQ-042 start with cfg_num_rows=0, and start while busy -> no state change, no pulses, cfg registers unchanged.
REQ-043 Reset during row 1 of channel 0 (C=3, H=4) -> pe_reset_n low the same cycle, all outputs 0 next cycle, no done; a following start with C=1, H=2 completes normally.
